// File: rtl/riscv_regfile_scoreboard.sv
// Register file with three combinational read ports, two write ports (B wins),
// per-register pending (scoreboard) bits and a sequential clear sweep.
// Optional same-cycle write-to-read forwarding: define RISCV_REGFILE_BYPASS_EN.
module riscv_regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int R0_ZERO    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic [DATA_WIDTH-1:0] rdata_c_o,
    output logic                  rbusy_a_o,
    output logic                  rbusy_b_o,
    output logic                  rbusy_c_o,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic                  we_a_i,
    input  logic [ADDR_WIDTH-1:0] waddr_b_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_i,
    input  logic                  we_b_i,
    input  logic                  rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
    input  logic                  flush_i,
    input  logic                  clear_req_i,
    output logic                  ready_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pend;

    logic                  w_run;
    logic                  w_start_clear;
    logic                  w_we_a;
    logic                  w_we_b;
    logic                  w_rsv;
    logic [NUM_REGS-1:0]   w_wr_mask;
    logic [NUM_REGS-1:0]   w_rsv_mask;

    logic [ADDR_WIDTH-1:0] w_raddr [3];
    logic [DATA_WIDTH-1:0] w_rdata [3];
    logic                  w_rbusy [3];

    assign w_run         = (r_state == ST_RUN);
    assign w_start_clear = w_run && clear_req_i;

    // Writes and reservations only act in RUN; address 0 is dropped when hard-wired.
    assign w_we_a = w_run && we_a_i && !((R0_ZERO != 0) && (waddr_a_i == '0));
    assign w_we_b = w_run && we_b_i && !((R0_ZERO != 0) && (waddr_b_i == '0));
    assign w_rsv  = w_run && rsv_valid_i && !((R0_ZERO != 0) && (rsv_addr_i == '0));

    always_comb begin
        w_wr_mask  = '0;
        w_rsv_mask = '0;
        if (w_we_a) w_wr_mask[waddr_a_i] = 1'b1;
        if (w_we_b) w_wr_mask[waddr_b_i] = 1'b1;
        if (w_rsv)  w_rsv_mask[rsv_addr_i] = 1'b1;
    end

    // Control FSM: counter walks the file once, ready_o is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (clear_req_i) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == '1) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Port B is applied after port A so it wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_we_a) r_mem[waddr_a_i] <= wdata_a_i;
            if (w_we_b) r_mem[waddr_b_i] <= wdata_b_i;
        end
    end

    // A reservation overrides a same-cycle write to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if ((r_state == ST_CLEAR) || w_start_clear || flush_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_wr_mask) | w_rsv_mask;
        end
    end

    assign w_raddr[0] = raddr_a_i;
    assign w_raddr[1] = raddr_b_i;
    assign w_raddr[2] = raddr_c_i;

    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            if ((R0_ZERO != 0) && (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
                w_rbusy[p] = 1'b0;
            end else begin
                w_rdata[p] = r_mem[w_raddr[p]];
                w_rbusy[p] = r_pend[w_raddr[p]];
`ifdef RISCV_REGFILE_BYPASS_EN
                if (w_run && we_b_i && (waddr_b_i == w_raddr[p])) begin
                    w_rdata[p] = wdata_b_i;
                    w_rbusy[p] = 1'b0;
                end else if (w_run && we_a_i && (waddr_a_i == w_raddr[p])) begin
                    w_rdata[p] = wdata_a_i;
                    w_rbusy[p] = 1'b0;
                end
`endif
            end
        end
    end

    assign rdata_a_o = w_rdata[0];
    assign rdata_b_o = w_rdata[1];
    assign rdata_c_o = w_rdata[2];
    assign rbusy_a_o = w_rbusy[0];
    assign rbusy_b_o = w_rbusy[1];
    assign rbusy_c_o = w_rbusy[2];
    assign ready_o   = r_ready;

endmodule

// File: tb/tb_riscv_regfile_scoreboard.sv
// Directed self-checking bench for riscv_regfile_scoreboard (default 32x32 file).
module tb_riscv_regfile_scoreboard;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef RISCV_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] raddr_a_i, raddr_b_i, raddr_c_i;
    logic [DW-1:0] rdata_a_o, rdata_b_o, rdata_c_o;
    logic          rbusy_a_o, rbusy_b_o, rbusy_c_o;
    logic [AW-1:0] waddr_a_i, waddr_b_i;
    logic [DW-1:0] wdata_a_i, wdata_b_i;
    logic          we_a_i, we_b_i;
    logic          rsv_valid_i;
    logic [AW-1:0] rsv_addr_i;
    logic          flush_i;
    logic          clear_req_i;
    logic          ready_o;

    int n_checks = 0;
    int n_errors = 0;

    riscv_regfile_scoreboard #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .R0_ZERO    (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raddr_a_i   (raddr_a_i),
        .raddr_b_i   (raddr_b_i),
        .raddr_c_i   (raddr_c_i),
        .rdata_a_o   (rdata_a_o),
        .rdata_b_o   (rdata_b_o),
        .rdata_c_o   (rdata_c_o),
        .rbusy_a_o   (rbusy_a_o),
        .rbusy_b_o   (rbusy_b_o),
        .rbusy_c_o   (rbusy_c_o),
        .waddr_a_i   (waddr_a_i),
        .wdata_a_i   (wdata_a_i),
        .we_a_i      (we_a_i),
        .waddr_b_i   (waddr_b_i),
        .wdata_b_i   (wdata_b_i),
        .we_b_i      (we_b_i),
        .rsv_valid_i (rsv_valid_i),
        .rsv_addr_i  (rsv_addr_i),
        .flush_i     (flush_i),
        .clear_req_i (clear_req_i),
        .ready_o     (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a_i      = 1'b0;
        we_b_i      = 1'b0;
        rsv_valid_i = 1'b0;
        flush_i     = 1'b0;
        clear_req_i = 1'b0;
    endtask

    task automatic fill_a5();
        for (int a = 1; a < 32; a++) begin
            we_a_i    = 1'b1;
            waddr_a_i = AW'(a);
            wdata_a_i = 32'hA5A5A5A5;
            tick();
        end
        we_a_i = 1'b0;
    endtask

    // Scans every address through port C; returns OR of all contents.
    task automatic scan_or(output logic [DW-1:0] acc);
        acc = '0;
        for (int a = 0; a < 32; a++) begin
            raddr_c_i = AW'(a);
            #1;
            acc = acc | rdata_c_o;
        end
    endtask

    initial begin
        int            cyc;
        logic [DW-1:0] acc;

        rst_n     = 1'b0;
        raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
        waddr_a_i = '0; waddr_b_i = '0; wdata_a_i = '0; wdata_b_i = '0;
        rsv_addr_i = '0;
        idle();
        raddr_a_i = 5'd5;
        #12;
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_rdata", rdata_a_o, 32'h0);
        check("reset_rbusy", 32'(rbusy_a_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write then read back next cycle; same-cycle read shows forwarding only with bypass.
        we_a_i = 1'b1; waddr_a_i = 5'd5; wdata_a_i = 32'hDEADBEEF;
        #1;
        check("wr5_same_cycle", rdata_a_o, BYP ? 32'hDEADBEEF : 32'h0);
        tick();
        idle();
        check("wr5_readback", rdata_a_o, 32'hDEADBEEF);

        we_a_i = 1'b1; waddr_a_i = 5'd0; wdata_a_i = 32'h1;
        tick();
        idle();
        raddr_b_i = 5'd0;
        #1;
        check("r0_zero", rdata_b_o, 32'h0);

        we_a_i = 1'b1; waddr_a_i = 5'd7; wdata_a_i = 32'h11;
        we_b_i = 1'b1; waddr_b_i = 5'd7; wdata_b_i = 32'h22;
        tick();
        idle();
        raddr_c_i = 5'd7;
        #1;
        check("portb_priority", rdata_c_o, 32'h22);

        // Scoreboard behaviour on register 3.
        raddr_a_i = 5'd3;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd3;
        #1;
        check("rsv3_not_yet", 32'(rbusy_a_o), 32'd0);
        tick();
        idle();
        check("rsv3_busy", 32'(rbusy_a_o), 32'd1);
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd3;
        we_a_i = 1'b1; waddr_a_i = 5'd3; wdata_a_i = 32'h3333;
        tick();
        idle();
        check("rsv_wr_same_busy", 32'(rbusy_a_o), 32'd1);
        check("rsv_wr_same_data", rdata_a_o, 32'h3333);
        we_b_i = 1'b1; waddr_b_i = 5'd3; wdata_b_i = 32'h4444;
        tick();
        idle();
        check("wr_clears_busy", 32'(rbusy_a_o), 32'd0);
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd3;
        tick();
        check("rsv3_again", 32'(rbusy_a_o), 32'd1);
        raddr_b_i = 5'd4;
        rsv_addr_i = 5'd4; flush_i = 1'b1;
        tick();
        idle();
        check("flush_clears", 32'(rbusy_a_o), 32'd0);
        check("flush_beats_rsv", 32'(rbusy_b_o), 32'd0);
        check("flush_keeps_data", rdata_a_o, 32'h4444);
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd0; raddr_b_i = 5'd0;
        tick();
        idle();
        check("rsv_r0_ignored", 32'(rbusy_b_o), 32'd0);

        // Bypass behaviour on register 9 (pending bit set to observe forcing).
        we_a_i = 1'b1; waddr_a_i = 5'd9; wdata_a_i = 32'h5555;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd9;
        tick();
        idle();
        raddr_a_i = 5'd9;
        we_a_i = 1'b1; waddr_a_i = 5'd9; wdata_a_i = 32'h1234;
        #1;
        check("byp_data", rdata_a_o, BYP ? 32'h1234 : 32'h5555);
        check("byp_busy", 32'(rbusy_a_o), BYP ? 32'd0 : 32'd1);
        tick();
        idle();
        check("wr9_readback", rdata_a_o, 32'h1234);

        // Clear sweep: writes/reservations during the sweep must be ignored.
        fill_a5();
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd6;
        tick();
        idle();
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        check("clear_ready_low", 32'(ready_o), 32'd0);
        we_a_i = 1'b1; waddr_a_i = 5'd1; wdata_a_i = 32'hFFFFFFFF;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd2;
        raddr_a_i = 5'd1; raddr_b_i = 5'd9; raddr_c_i = 5'd10;
        cyc = 0;
        while (!ready_o && cyc < 100) begin
            tick();
            cyc++;
            if (cyc == 10) begin
                check("sweep_partial_lo", rdata_b_o, 32'h0);
                check("sweep_partial_hi", rdata_c_o, 32'hA5A5A5A5);
                check("sweep_no_byp", rdata_a_o, 32'h0);
            end
        end
        idle();
        check("sweep_cycles", 32'(cyc), 32'd32);
        scan_or(acc);
        check("sweep_all_zero", acc, 32'h0);
        raddr_a_i = 5'd6; raddr_b_i = 5'd2;
        #1;
        check("sweep_pend6_clr", 32'(rbusy_a_o), 32'd0);
        check("sweep_rsv_ignored", 32'(rbusy_b_o), 32'd0);

        // Reset during a sweep.
        fill_a5();
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("midsweep_ready_low", 32'(ready_o), 32'd0);
        #2;
        rst_n = 1'b0;
        raddr_a_i = 5'd20;
        #1;
        check("async_rst_ready", 32'(ready_o), 32'd1);
        check("async_rst_data", rdata_a_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(ready_o), 32'd1);
        scan_or(acc);
        check("post_rst_zero", acc, 32'h0);
        we_a_i = 1'b1; waddr_a_i = 5'd12; wdata_a_i = 32'hCAFE0012;
        tick();
        idle();
        raddr_a_i = 5'd12;
        #1;
        check("post_rst_run_wr", rdata_a_o, 32'hCAFE0012);
        check("post_rst_ready2", 32'(ready_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_regfile_scoreboard.md
RISCV_REGFILE_SCOREBOARD -- requirements
Module: riscv_regfile_scoreboard

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width; NUM_REGS = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 Parameter R0_ZERO, default 1, register 0 hard-wired to zero when 1.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 raddr_{a,b,c}_i  in  ADDR_WIDTH  read addresses, three independent combinational ports.
REQ-007 rdata_{a,b,c}_o  out  DATA_WIDTH  read data.
REQ-008 rbusy_{a,b,c}_o  out  1  addressed register has a pending reservation.
REQ-009 waddr_{a,b}_i / wdata_{a,b}_i / we_{a,b}_i  in  ADDR_WIDTH/DATA_WIDTH/1  write ports A and B.
REQ-010 rsv_valid_i / rsv_addr_i  in  1/ADDR_WIDTH  reserve destination register (sets pending bit).
REQ-011 flush_i  in  1  clear all pending bits.
REQ-012 clear_req_i  in  1  start sequential zeroing of whole file.
REQ-013 ready_o  out  1  file available; low during clear sweep.

Function
REQ-014 Writes SHALL take effect at the rising edge when we_x_i=1; read returns new value from next cycle.
REQ-015 Same address on both write ports SHALL store wdata_b_i (port B priority).
REQ-016 With R0_ZERO=1, writes and reservations to address 0 SHALL be ignored; reads of 0 return 0, rbusy 0.
REQ-017 Pending bit SHALL set on rsv_valid_i and clear on any write to that address.
REQ-018 Reservation and write to same address in same cycle: pending bit SHALL end set (new reservation wins).
REQ-019 flush_i SHALL clear all pending bits at the edge and override same-cycle rsv_valid_i; data unchanged.
REQ-020 rbusy_x_o SHALL reflect registered pending bits (combinational on raddr, not on same-cycle writes).
REQ-021 FSM states RUN and CLEAR; reset state RUN.
REQ-022 RUN->CLEAR on clear_req_i; 5-bit-wide (ADDR_WIDTH) counter starts at 0, zeroes one register per cycle.
REQ-023 CLEAR->RUN after register NUM_REGS-1 written; sweep lasts exactly NUM_REGS cycles; ready_o low throughout.
REQ-024 In CLEAR, write ports and rsv_valid_i SHALL be ignored; all pending bits cleared on entry; clear_req_i ignored.
REQ-025 Reads during CLEAR SHALL return current contents (partially swept).

Reset
REQ-026 rst_n low SHALL asynchronously zero all registers and pending bits, FSM to RUN, counter to 0.
REQ-027 Reset values: rdata_x_o 0 (for all-zero file), rbusy_x_o 0, ready_o 1.
REQ-028 Reset asserted mid-sweep SHALL abort CLEAR; file zero on release.

Configuration
REQ-029 Macro RISCV_REGFILE_BYPASS_EN defined: read port SHALL return same-cycle wdata when we active to its address (B over A), rbusy forced 0 for that port.
REQ-030 Macro undefined: no bypass; reads return registered contents only, per REQ-014/REQ-020.
REQ-031 Bypass SHALL never apply to address 0 with R0_ZERO=1, nor during CLEAR.

Verification
REQ-032 Write A addr 5 0xDEADBEEF, next cycle read a=5 -> 0xDEADBEEF; read addr 0 after write 0x1 -> 0.
REQ-033 we_a and we_b both addr 7 (0x11, 0x22) -> addr 7 reads 0x22.
REQ-034 rsv addr 3 -> rbusy 1 next cycle; write addr 3 with rsv addr 3 same cycle -> rbusy stays 1; flush -> 0.
REQ-035 Fill regs 1..31 with 0xA5A5A5A5, pulse clear_req_i -> ready_o low 32 cycles, all regs 0, ready_o 1.
REQ-036 Reset at sweep cycle 10 -> ready_o 1, all regs 0, FSM RUN after release.
REQ-037 Bypass on: write addr 9 0x1234 with raddr_a=9 same cycle -> rdata_a 0x1234; bypass off -> old value.
